// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline stage register with a valid/ready handshake, a two-entry skid
// buffer for back-pressure, synchronous flush and zero-register write-back suppression.
// State updates on the falling clock edge, matching the other pipeline registers.
module mem_wb_pipe_reg #(
    parameter int unsigned DATA_W           = 32,
    parameter int unsigned RD_W             = 5,
    parameter int unsigned WB_W             = 2,
    parameter bit          ZERO_RD_SUPPRESS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   in_wb,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DATA_W-1:0] in_alu_data,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   out_wb,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [DATA_W-1:0] out_alu_data,
    output logic [RD_W-1:0]   out_rd,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] alu_data;
        logic [RD_W-1:0]   rd;
    } entry_t;

    // Entry validity is implied by the state: main is valid in StOne/StFull,
    // skid only in StFull.
    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;

    logic accept;
    logic pop;

    assign in_entry = {in_wb, in_mem_data, in_alu_data, in_rd};

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next-state and entry movement; flush drops validity but leaves the data fields.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_d  = in_entry;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (accept && pop) begin
                        main_d = in_entry;
                    end else if (accept) begin
                        skid_d  = in_entry;
                        state_d = StFull;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    // in_ready is low here, so only a pop can change anything.
                    if (pop) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = StOne;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end
    end

    // State register; synchronous active-low reset clears everything and wins over flush.
    always_ff @(negedge clk) begin
        if (!rst) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Head-entry outputs; write-back control is masked for bubbles and optionally for r0.
    always_comb begin
        out_mem_data = main_q.mem_data;
        out_alu_data = main_q.alu_data;
        out_rd       = main_q.rd;
        out_wb       = '0;
        if (out_valid) begin
            out_wb = main_q.wb;
        end
        if (ZERO_RD_SUPPRESS && (main_q.rd == '0)) begin
            out_wb = '0;
        end
    end

    // Occupancy count from the registered state.
    always_comb begin
        occupancy = 2'd0;
        unique case (state_q)
            StEmpty: occupancy = 2'd0;
            StOne:   occupancy = 2'd1;
            StFull:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed bench for mem_wb_pipe_reg: a vector table walked once per falling edge,
// plus short hand sequences for 64-bit payloads and flush-with-pop.
module tb_mem_wb_pipe_reg;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [1:0]  in_wb;
    logic [4:0]  in_rd;
    logic [63:0] in_alu64;
    logic [63:0] in_mem64;

    // Default build
    logic        in_ready;
    logic        out_valid;
    logic [1:0]  out_wb;
    logic [31:0] out_mem_data;
    logic [31:0] out_alu_data;
    logic [4:0]  out_rd;
    logic [1:0]  occupancy;

    // ZERO_RD_SUPPRESS = 0 build
    logic        nz_in_ready;
    logic        nz_out_valid;
    logic [1:0]  nz_out_wb;
    logic [31:0] nz_out_mem_data;
    logic [31:0] nz_out_alu_data;
    logic [4:0]  nz_out_rd;
    logic [1:0]  nz_occupancy;

    // DATA_W = 64 build
    logic        w_in_ready;
    logic        w_out_valid;
    logic [1:0]  w_out_wb;
    logic [63:0] w_out_mem_data;
    logic [63:0] w_out_alu_data;
    logic [4:0]  w_out_rd;
    logic [1:0]  w_occupancy;

    int n_cmp = 0;
    int n_bad = 0;

    mem_wb_pipe_reg dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_wb        (in_wb),
        .in_mem_data  (in_mem64[31:0]),
        .in_alu_data  (in_alu64[31:0]),
        .in_rd        (in_rd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_wb       (out_wb),
        .out_mem_data (out_mem_data),
        .out_alu_data (out_alu_data),
        .out_rd       (out_rd),
        .occupancy    (occupancy)
    );

    mem_wb_pipe_reg #(
        .ZERO_RD_SUPPRESS (1'b0)
    ) dut_nz (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (nz_in_ready),
        .in_wb        (in_wb),
        .in_mem_data  (in_mem64[31:0]),
        .in_alu_data  (in_alu64[31:0]),
        .in_rd        (in_rd),
        .out_valid    (nz_out_valid),
        .out_ready    (out_ready),
        .out_wb       (nz_out_wb),
        .out_mem_data (nz_out_mem_data),
        .out_alu_data (nz_out_alu_data),
        .out_rd       (nz_out_rd),
        .occupancy    (nz_occupancy)
    );

    mem_wb_pipe_reg #(
        .DATA_W (64)
    ) dut_w64 (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (w_in_ready),
        .in_wb        (in_wb),
        .in_mem_data  (in_mem64),
        .in_alu_data  (in_alu64),
        .in_rd        (in_rd),
        .out_valid    (w_out_valid),
        .out_ready    (out_ready),
        .out_wb       (w_out_wb),
        .out_mem_data (w_out_mem_data),
        .out_alu_data (w_out_alu_data),
        .out_rd       (w_out_rd),
        .occupancy    (w_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic        ordy;
        logic [1:0]  wb;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] mem;
        logic        ev;
        logic [1:0]  ewb;
        logic [1:0]  ewb_nz;
        logic [4:0]  erd;
        logic [31:0] ealu;
        logic [31:0] emem;
        logic [1:0]  eocc;
        logic        erdy;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    function automatic vec_t mk(
        input logic r, input logic f, input logic iv, input logic ordy,
        input logic [1:0] wb, input logic [4:0] rd, input logic [31:0] alu,
        input logic [31:0] mem, input logic ev, input logic [1:0] ewb,
        input logic [1:0] ewb_nz, input logic [4:0] erd, input logic [31:0] ealu,
        input logic [31:0] emem, input logic [1:0] eocc, input logic erdy);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.ordy = ordy;
        v.wb = wb; v.rd = rd; v.alu = alu; v.mem = mem;
        v.ev = ev; v.ewb = ewb; v.ewb_nz = ewb_nz; v.erd = erd;
        v.ealu = ealu; v.emem = emem; v.eocc = eocc; v.erdy = erdy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Advance through one falling (active) edge, then settle before sampling.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_wb = '0; in_rd = '0; in_alu64 = '0; in_mem64 = '0;

        //           rst f  iv rdy wb     rd     alu            mem        | ev ewb   ewbnz erd    ealu           emem       occ   rdy
        vecs[0]  = mk(0, 0, 1, 0, 2'd3, 5'd1,  32'h11,        32'h21,     0, 2'd0, 2'd0, 5'd0,  32'h0,         32'h0,     2'd0, 1);
        vecs[1]  = mk(0, 0, 1, 0, 2'd3, 5'd1,  32'h11,        32'h21,     0, 2'd0, 2'd0, 5'd0,  32'h0,         32'h0,     2'd0, 1);
        vecs[2]  = mk(1, 0, 1, 1, 2'd1, 5'd5,  32'h0000_1234, 32'ha5,     1, 2'd1, 2'd1, 5'd5,  32'h0000_1234, 32'ha5,    2'd1, 1);
        vecs[3]  = mk(1, 0, 1, 1, 2'd1, 5'd6,  32'hDEAD_BEEF, 32'ha6,     1, 2'd1, 2'd1, 5'd6,  32'hDEAD_BEEF, 32'ha6,    2'd1, 1);
        vecs[4]  = mk(1, 0, 0, 1, 2'd2, 5'd31, 32'hFFFF,      32'hFF,     0, 2'd0, 2'd0, 5'd6,  32'hDEAD_BEEF, 32'ha6,    2'd0, 1);
        vecs[5]  = mk(1, 0, 1, 0, 2'd1, 5'd7,  32'h7,         32'h77,     1, 2'd1, 2'd1, 5'd7,  32'h7,         32'h77,    2'd1, 1);
        vecs[6]  = mk(1, 0, 1, 0, 2'd1, 5'd8,  32'h8,         32'h88,     1, 2'd1, 2'd1, 5'd7,  32'h7,         32'h77,    2'd2, 0);
        vecs[7]  = mk(1, 0, 1, 0, 2'd1, 5'd9,  32'h9,         32'h99,     1, 2'd1, 2'd1, 5'd7,  32'h7,         32'h77,    2'd2, 0);
        vecs[8]  = mk(1, 0, 1, 1, 2'd1, 5'd9,  32'h9,         32'h99,     1, 2'd1, 2'd1, 5'd8,  32'h8,         32'h88,    2'd1, 1);
        vecs[9]  = mk(1, 0, 1, 1, 2'd1, 5'd9,  32'h9,         32'h99,     1, 2'd1, 2'd1, 5'd9,  32'h9,         32'h99,    2'd1, 1);
        vecs[10] = mk(1, 0, 0, 1, 2'd0, 5'd0,  32'h0,         32'h0,      0, 2'd0, 2'd0, 5'd9,  32'h9,         32'h99,    2'd0, 1);
        vecs[11] = mk(1, 0, 1, 0, 2'd1, 5'd3,  32'h3,         32'h33,     1, 2'd1, 2'd1, 5'd3,  32'h3,         32'h33,    2'd1, 1);
        vecs[12] = mk(1, 0, 1, 0, 2'd1, 5'd4,  32'h4,         32'h44,     1, 2'd1, 2'd1, 5'd3,  32'h3,         32'h33,    2'd2, 0);
        vecs[13] = mk(1, 1, 1, 0, 2'd1, 5'd10, 32'hA,         32'hAA,     0, 2'd0, 2'd0, 5'd3,  32'h3,         32'h33,    2'd0, 1);
        vecs[14] = mk(1, 0, 0, 1, 2'd1, 5'd10, 32'hA,         32'hAA,     0, 2'd0, 2'd0, 5'd3,  32'h3,         32'h33,    2'd0, 1);
        vecs[15] = mk(1, 0, 1, 0, 2'd3, 5'd0,  32'h55,        32'h66,     1, 2'd0, 2'd3, 5'd0,  32'h55,        32'h66,    2'd1, 1);
        vecs[16] = mk(1, 0, 0, 0, 2'd3, 5'd0,  32'h55,        32'h66,     1, 2'd0, 2'd3, 5'd0,  32'h55,        32'h66,    2'd1, 1);
        vecs[17] = mk(1, 0, 1, 0, 2'd1, 5'd12, 32'hC,         32'hCC,     1, 2'd0, 2'd3, 5'd0,  32'h55,        32'h66,    2'd2, 0);
        vecs[18] = mk(0, 1, 1, 1, 2'd1, 5'd12, 32'hC,         32'hCC,     0, 2'd0, 2'd0, 5'd0,  32'h0,         32'h0,     2'd0, 1);
        vecs[19] = mk(1, 0, 0, 0, 2'd0, 5'd0,  32'h0,         32'h0,      0, 2'd0, 2'd0, 5'd0,  32'h0,         32'h0,     2'd0, 1);

        for (int i = 0; i < NV; i++) begin
            rst       = vecs[i].rst;
            flush     = vecs[i].flush;
            in_valid  = vecs[i].iv;
            out_ready = vecs[i].ordy;
            in_wb     = vecs[i].wb;
            in_rd     = vecs[i].rd;
            in_alu64  = {32'h0, vecs[i].alu};
            in_mem64  = {32'h0, vecs[i].mem};
            tick();
            chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vecs[i].ev));
            chk($sformatf("v%0d out_wb", i), 64'(out_wb), 64'(vecs[i].ewb));
            chk($sformatf("v%0d out_rd", i), 64'(out_rd), 64'(vecs[i].erd));
            chk($sformatf("v%0d out_alu_data", i), 64'(out_alu_data), 64'(vecs[i].ealu));
            chk($sformatf("v%0d out_mem_data", i), 64'(out_mem_data), 64'(vecs[i].emem));
            chk($sformatf("v%0d occupancy", i), 64'(occupancy), 64'(vecs[i].eocc));
            chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vecs[i].erdy));
            chk($sformatf("v%0d nz out_wb", i), 64'(nz_out_wb), 64'(vecs[i].ewb_nz));
            chk($sformatf("v%0d w64 out_alu_data", i), w_out_alu_data, {32'h0, vecs[i].ealu});
        end

        // 64-bit payload streaming
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_wb = 2'd1; in_rd = 5'd5;
        in_alu64 = 64'h0123_4567_89AB_CDEF; in_mem64 = 64'h1111_2222_3333_4444;
        tick();
        chk("w64 s1 valid", 64'(w_out_valid), 64'd1);
        chk("w64 s1 alu", w_out_alu_data, 64'h0123_4567_89AB_CDEF);
        chk("w64 s1 mem", w_out_mem_data, 64'h1111_2222_3333_4444);
        chk("w32 s1 alu", 64'(out_alu_data), 64'h89AB_CDEF);
        in_rd = 5'd6; in_alu64 = 64'hFEDC_BA98_7654_3210;
        tick();
        chk("w64 s2 rd", 64'(w_out_rd), 64'd6);
        chk("w64 s2 alu", w_out_alu_data, 64'hFEDC_BA98_7654_3210);
        chk("w64 s2 occ", 64'(w_occupancy), 64'd1);
        in_valid = 1'b0;
        tick();
        chk("w64 s3 valid", 64'(w_out_valid), 64'd0);

        // Flush coinciding with a pop in ONE: the popped entry is not re-presented
        in_valid = 1'b1; out_ready = 1'b0; in_rd = 5'd14; in_wb = 2'd1;
        in_alu64 = 64'hE; in_mem64 = 64'hEE;
        tick();
        chk("fp accept valid", 64'(out_valid), 64'd1);
        chk("fp accept rd", 64'(out_rd), 64'd14);
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
        tick();
        chk("fp flush valid", 64'(out_valid), 64'd0);
        chk("fp flush occ", 64'(occupancy), 64'd0);
        flush = 1'b0;
        tick();
        chk("fp after valid", 64'(out_valid), 64'd0);
        chk("fp after wb", 64'(out_wb), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
